// File: rtl/multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial sum per RUN cycle through a
// single adder instance, result held on o_product until the next accepted start.

module adder #(
    parameter int unsigned BITS = 4
) (
    input  logic [BITS-1:0] i_augend,
    input  logic [BITS-1:0] i_addend,
    output logic [BITS-1:0] o_sum,
    output logic            o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_augend} + {1'b0, i_addend};

endmodule

module multiplier #(
    parameter int unsigned BITS = 4
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [BITS-1:0]   i_multiplicand,
    input  logic [BITS-1:0]   i_multiplier,
    output logic              o_busy,
    output logic              o_done,
    output logic [2*BITS-1:0] o_product
);

    localparam int unsigned CntW = $clog2(BITS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [BITS-1:0] a_q, a_d;
    logic [BITS-1:0] q_q, q_d;
    logic [BITS-1:0] m_q, m_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [BITS-1:0] addend;
    logic [BITS-1:0] sum;
    logic            carry;

    assign addend = q_q[0] ? m_q : '0;

    adder #(
        .BITS (BITS)
    ) u_adder (
        .i_augend (a_q),
        .i_addend (addend),
        .o_sum    (sum),
        .o_carry  (carry)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    m_d     = i_multiplicand;
                    q_d     = i_multiplier;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Carry becomes the new MSB of A so no partial-sum bit is lost.
                {a_d, q_d} = {carry, sum, q_q[BITS-1:1]};
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CntW'(BITS - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_busy    = (state_q == StRun);
    assign o_done    = (state_q == StDone);
    assign o_product = {a_q, q_q};

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: cycle-level behavioural model plus directed and
// randomized stimulus.

module tb_multiplier;

    localparam int unsigned BITS = 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [BITS-1:0]   cand;
    logic [BITS-1:0]   mult;
    logic              busy;
    logic              done;
    logic [2*BITS-1:0] product;

    int n_cmp;
    int n_err;

    multiplier #(
        .BITS (BITS)
    ) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_start        (start),
        .i_multiplicand (cand),
        .i_multiplier   (mult),
        .o_busy         (busy),
        .o_done         (done),
        .o_product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = idle, 1..BITS = cycles of work, BITS+1 = result cycle.
    int unsigned       ph;
    logic [2*BITS-1:0] exp_prod;
    logic [2*BITS-1:0] held_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph        = 0;
            exp_prod  = '0;
            held_prod = '0;
        end else if (ph == 0) begin
            if (start) begin
                exp_prod = (2*BITS)'(int'(cand) * int'(mult));
                ph       = 1;
            end
        end else if (ph == BITS + 1) begin
            ph = 0;
        end else begin
            ph = ph + 1;
            if (ph == BITS + 1) held_prod = exp_prod;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("busy", int'(busy), int'(ph >= 1 && ph <= BITS));
        chk("done", int'(done), int'(ph == BITS + 1));
        if (ph == 0 || ph == BITS + 1) chk("product", int'(product), int'(held_prod));
    end

    task automatic do_op(input int a, input int b, input int exp_p);
        bit seen;
        @(negedge clk);
        start = 1'b1;
        cand  = BITS'(a);
        mult  = BITS'(b);
        @(negedge clk);
        start = 1'b0;
        cand  = BITS'($urandom);
        mult  = BITS'($urandom);
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", int'(seen), 1);
        chk("op_product", int'(product), exp_p);
    endtask

    initial begin
        int dones;
        int last_t;
        int t;
        n_cmp = 0;
        n_err = 0;
        start = 1'b0;
        cand  = '0;
        mult  = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_product", int'(product), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 15*15: four busy cycles, done on the fifth, product held afterwards.
        start = 1'b1;
        cand  = 4'd15;
        mult  = 4'd15;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("lat_busy", int'(busy), 1);
            chk("lat_nodone", int'(done), 0);
            @(negedge clk);
        end
        chk("lat_done", int'(done), 1);
        chk("lat_busy_off", int'(busy), 0);
        chk("lat_product", int'(product), 225);
        @(negedge clk);
        chk("lat_done_pulse", int'(done), 0);
        chk("lat_hold", int'(product), 225);

        do_op(0, 13, 0);
        do_op(13, 0, 0);
        do_op(1, 9, 9);
        do_op(8, 2, 16);

        // Second request during RUN must be ignored.
        @(negedge clk);
        start = 1'b1;
        cand  = 4'd6;
        mult  = 4'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        cand  = 4'd3;
        mult  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                dones++;
                chk("ign_product", int'(product), 42);
            end
            @(negedge clk);
        end
        chk("ign_done_count", dones, 1);

        // Reset after the second RUN edge aborts with no done.
        start = 1'b1;
        cand  = 4'd15;
        mult  = 4'd15;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_product", int'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("abort_no_done", dones, 0);
        do_op(5, 5, 25);

        // Held start: one result every BITS+2 cycles.
        @(negedge clk);
        start  = 1'b1;
        cand   = 4'd12;
        mult   = 4'd11;
        dones  = 0;
        last_t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                t = i;
                chk("held_product", int'(product), 132);
                if (last_t >= 0) chk("held_period", t - last_t, BITS + 2);
                last_t = t;
                dones++;
            end
        end
        start = 1'b0;
        chk("held_done_count", int'(dones >= 6), 1);
        repeat (8) @(negedge clk);

        // Exhaustive operand sweep.
        for (int x = 0; x < (1 << BITS); x++) begin
            for (int y = 0; y < (1 << BITS); y++) begin
                do_op(x, y, x * y);
            end
        end

        // Randomized traffic with occasional resets; the model checks every cycle.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            cand  = BITS'($urandom);
            mult  = BITS'($urandom);
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL have parameter BITS, default 4, giving the operand width; the product is 2*BITS wide.
REQ-002 SHALL have port i_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port i_start, input, 1 bit: request to begin a multiplication.
REQ-005 SHALL have port i_multiplicand, input, BITS: unsigned multiplicand, sampled on the accepting edge.
REQ-006 SHALL have port i_multiplier, input, BITS: unsigned multiplier, sampled on the accepting edge.
REQ-007 SHALL have port o_busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port o_done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 SHALL have port o_product, output, 2*BITS: unsigned product.

Function
REQ-010 SHALL implement unsigned shift-and-add multiplication that forms every partial sum through one internal instance of the team's Adder module (parameter BITS; ports i_augend, i_addend, o_sum, o_carry), with no other adder in the datapath.
REQ-011 SHALL hold these internal registers: accumulator A (BITS), multiplier/low-product Q (BITS), multiplicand M (BITS), and an iteration counter of width clog2(BITS+1).
REQ-012 SHALL implement a state machine with exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE: at an edge with i_start=1, the block SHALL load M<=i_multiplicand, Q<=i_multiplier, A<=0 and counter<=0, and enter RUN; with i_start=0 it SHALL stay in IDLE with all registers unchanged.
REQ-014 RUN, each edge: the Adder SHALL be driven with augend=A and addend=(Q[0] ? M : 0); then {A,Q} <= {o_carry, o_sum, Q[BITS-1:1]} and the counter increments.
REQ-015 RUN SHALL last exactly BITS edges; on the edge where the counter reaches BITS-1, the state SHALL become DONE.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-017 o_busy SHALL be 1 exactly when the state is RUN.
REQ-018 o_done SHALL be 1 exactly when the state is DONE.
REQ-019 o_product SHALL equal {A,Q} at all times; it is valid in DONE and stays valid through the following IDLE cycles until the next start is accepted.
REQ-020 Latency: if i_start is accepted at edge k, o_done SHALL be high between edge k+BITS and edge k+BITS+1, so back-to-back throughput is one result per BITS+2 cycles.
REQ-021 i_start SHALL be ignored in RUN and DONE; operand inputs SHALL be ignored everywhere except on the accepting edge.
REQ-022 Arithmetic SHALL be exact for all operands: the result equals i_multiplicand*i_multiplier modulo 2^(2*BITS), which for unsigned operands is always exact; a carry out of any partial sum SHALL never be lost.
REQ-023 A held-high i_start SHALL start a new operation on the first IDLE edge after DONE.

Reset
REQ-024 While i_reset_n=0, the block SHALL immediately (asynchronously) force state=IDLE and A, Q, M and counter to 0, giving o_busy=0, o_done=0 and o_product=0.
REQ-025 Reset asserted mid-RUN or during DONE SHALL abort the operation with no o_done pulse; after release, the first rising edge SHALL be treated as an IDLE edge.
REQ-026 No output SHALL take an X or undefined value after reset.

Verification
REQ-027 BITS=4, multiplicand 15, multiplier 15, start at edge k -> o_busy high for 4 cycles, o_done pulse after edge k+4, o_product=225 (8'hE1).
REQ-028 Exhaustive test, BITS=4: all 256 operand pairs -> o_product equals x*y at each o_done pulse, with exactly one o_done per accepted start.
REQ-029 Operands 0*13 and 13*0 -> o_product=0; 1*9 -> 9; 8*2 -> 16.
REQ-030 Start 6*7, then i_start pulsed again mid-RUN with operands 3*3 -> second request ignored; single o_done with o_product=42.
REQ-031 Start 15*15, then i_reset_n low for one cycle after the second RUN edge -> outputs 0 immediately, no o_done; a subsequent start 5*5 yields 25.
REQ-032 i_start held high continuously with operands fixed at 12*11 -> o_done every 6 cycles (BITS+2), each with o_product=132.
